// File: rtl/mem_stage_pkg.sv
// Shared widths, op/state codes and bus structs for the MEM pipeline stage.
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int STALL_W      = 6;
  localparam int STAGE_MEM    = 3;
  localparam int STAGE_WB     = 4;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [2:0]  mem_op;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  function automatic logic is_load(input ex_to_mem_t r);
    return r.ram_en && (r.ram_wen == 4'b0000);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side bus bundle of the MEM stage: EX input, SRAM read return, WB/forward outputs.
interface mem_stage_if;
  logic [mem_stage_pkg::STALL_W-1:0]      stall;
  logic [mem_stage_pkg::EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]                            data_sram_rdata;
  logic                                   data_sram_rvalid;
  logic [mem_stage_pkg::MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [mem_stage_pkg::MEM_TO_RF_WD-1:0] mem_to_rf_bus;
  logic                                   stallreq_for_mem;
  logic                                   addr_err;

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
    output mem_to_wb_bus, mem_to_rf_bus, stallreq_for_mem, addr_err
  );

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
    input  mem_to_wb_bus, mem_to_rf_bus, stallreq_for_mem, addr_err
  );
endinterface

// File: rtl/mem_stage_load_ext.sv
// Load lane select and sign/zero extension; reserved op codes return the full word.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] data_o
);
  logic [3:0][7:0] lanes;
  logic [7:0]      b;
  logic [15:0]     h;

  assign lanes = word_i;
  assign b     = lanes[addr_i];
  assign h     = addr_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (op_i)
      OP_LB:   data_o = {{24{b[7]}}, b};
      OP_LBU:  data_o = {24'b0, b};
      OP_LH:   data_o = {{16{h[15]}}, h};
      OP_LHU:  data_o = {16'b0, h};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: input register, load-return FSM (IDLE/WAIT/HELD), load extension.
// Optional MEM_ALIGN_CHECK_EN flags misaligned LW/LH/LHU and suppresses their write-back.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
);
  ex_to_mem_t  r_q, r_d;
  mem_state_e  state_q;
  logic [31:0] data_buf_q;

  logic        st_mem, st_wb, advance;
  logic        ld, ld_act, align_err, stallreq, rf_we;
  logic [31:0] raw_word, ld_data, rf_wdata;
  mem_to_wb_t  wb;
  logic        unused_stall;

  assign st_mem  = bus.stall[STAGE_MEM];
  assign st_wb   = bus.stall[STAGE_WB];
  // Register moves on either a normal advance or a bubble insert.
  assign advance = (st_mem == NoStop) || (st_wb == NoStop);
  assign unused_stall = ^{bus.stall[2:0], bus.stall[STALL_W-1]};

  always_comb begin
    r_d = r_q;
    if (st_mem == Stop && st_wb == NoStop) r_d = '0;
    else if (st_mem == NoStop)             r_d = bus.ex_to_mem_bus;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_q <= '0;
    else         r_q <= r_d;
  end

  assign ld = is_load(r_q);

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    align_err = 1'b0;
    if (ld) begin
      case (r_q.mem_op)
        OP_LB, OP_LBU: align_err = 1'b0;
        OP_LH, OP_LHU: align_err = r_q.ex_result[0];
        default:       align_err = (r_q.ex_result[1:0] != 2'b00);
      endcase
    end
  end
`else
  assign align_err = 1'b0;
`endif

  // A misaligned load never waits for memory.
  assign ld_act   = ld && !align_err;
  assign stallreq = ld_act && (state_q != ST_HELD) && !bus.data_sram_rvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      data_buf_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_act) begin
            if (!bus.data_sram_rvalid) begin
              state_q <= ST_WAIT;
            end else begin
              data_buf_q <= bus.data_sram_rdata;
              if (st_mem == Stop) state_q <= ST_HELD;
            end
          end
        end
        ST_WAIT: begin
          if (bus.data_sram_rvalid) begin
            data_buf_q <= bus.data_sram_rdata;
            state_q    <= (st_mem == Stop) ? ST_HELD : ST_IDLE;
          end
        end
        ST_HELD: begin
          if (advance) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign raw_word = bus.data_sram_rvalid ? bus.data_sram_rdata : data_buf_q;

  load_ext u_load_ext (
    .word_i (raw_word),
    .op_i   (r_q.mem_op),
    .addr_i (r_q.ex_result[1:0]),
    .data_o (ld_data)
  );

  assign rf_wdata = r_q.sel_rf_res ? ld_data : r_q.ex_result;
  // Forwarding must never see a load result before its data has arrived.
  assign rf_we    = r_q.rf_we && !stallreq && !align_err;

  assign wb.pc       = r_q.pc;
  assign wb.rf_we    = rf_we;
  assign wb.rf_waddr = r_q.rf_waddr;
  assign wb.rf_wdata = rf_wdata;

  assign bus.mem_to_wb_bus    = wb;
  assign bus.mem_to_rf_bus    = {rf_we, r_q.rf_waddr, rf_wdata};
  assign bus.stallreq_for_mem = stallreq;
  assign bus.addr_err         = align_err;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-backs queued at issue, popped when committed.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [STALL_W-1:0] tb_stall = '0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [69:0] sb_q[$];

  mem_stage_if ifc ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  // Pipeline controller: a MEM stall request freezes stages 0..4.
  assign ifc.stall = tb_stall | (ifc.stallreq_for_mem ? 6'b011111 : 6'b000000);

  task automatic chk(input string tag, input logic [69:0] act, input logic [69:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc, input logic ld,
                                     input logic sel, input logic we, input logic [4:0] wa,
                                     input logic [31:0] res);
    return {op, pc, ld, 4'b0000, sel, we, wa, res};
  endfunction

  // Commit = valid write leaving MEM this cycle.
  always @(negedge clk) begin
    if (resetn && ifc.mem_to_wb_bus[37] && ifc.stall[3] == 1'b0) begin
      if (sb_q.size() == 0) chk("wb_unexpected", ifc.mem_to_wb_bus, 70'(0));
      else                  chk("wb", ifc.mem_to_wb_bus, sb_q.pop_front());
    end
  end

  task automatic do_load(input string tag, input logic [78:0] ins, input int dly,
                         input logic [31:0] rd, input logic [31:0] exp);
    int n;
    logic [4:0] wa;
    n  = 0;
    wa = ins[36:32];
    ifc.ex_to_mem_bus = ins;
    sb_q.push_back({ins[75:44], 1'b1, wa, exp});
    tick();
    ifc.ex_to_mem_bus = '0;
    for (int i = 0; i < dly; i++) begin
      #1;
      if (ifc.stallreq_for_mem) n++;
      chk({tag, "_rfwe_in_stall"}, 70'(ifc.mem_to_rf_bus[37]), 70'(0));
      tick();
    end
    ifc.data_sram_rvalid = 1'b1;
    ifc.data_sram_rdata  = rd;
    #1;
    chk({tag, "_stall_cycles"}, 70'(n), 70'(dly));
    chk({tag, "_stallreq_at_rvalid"}, 70'(ifc.stallreq_for_mem), 70'(0));
    chk({tag, "_rf"}, 70'(ifc.mem_to_rf_bus), 70'({1'b1, wa, exp}));
    tick();
    ifc.data_sram_rvalid = 1'b0;
    ifc.data_sram_rdata  = '0;
  endtask

  initial begin
    ifc.ex_to_mem_bus    = '0;
    ifc.data_sram_rdata  = '0;
    ifc.data_sram_rvalid = 1'b0;
    #1 resetn = 1'b0;
    #3;
    chk("rst_wb", 70'(ifc.mem_to_wb_bus), 70'(0));
    chk("rst_rf", 70'(ifc.mem_to_rf_bus), 70'(0));
    chk("rst_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    tick();
    tick();
    resetn = 1'b1;
    tick();

    do_load("lw",   mk(3'd0, 32'h1000, 1'b1, 1'b1, 1'b1, 5'd5, 32'h100), 3, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb",   mk(3'd1, 32'h1004, 1'b1, 1'b1, 1'b1, 5'd6, 32'h103), 1, 32'h80FF1234, 32'hFFFFFF80);
    do_load("lbu",  mk(3'd2, 32'h1008, 1'b1, 1'b1, 1'b1, 5'd7, 32'h103), 2, 32'h80FF1234, 32'h00000080);
    do_load("lh",   mk(3'd3, 32'h100C, 1'b1, 1'b1, 1'b1, 5'd8, 32'h102), 1, 32'h80010000, 32'hFFFF8001);
    do_load("lhu",  mk(3'd4, 32'h1010, 1'b1, 1'b1, 1'b1, 5'd9, 32'h102), 0, 32'h80010000, 32'h00008001);
    do_load("lb0",  mk(3'd1, 32'h1014, 1'b1, 1'b1, 1'b1, 5'd10, 32'h100), 1, 32'h0000007F, 32'h0000007F);
    do_load("rsvd", mk(3'd6, 32'h1018, 1'b1, 1'b1, 1'b1, 5'd11, 32'h100), 1, 32'hCAFEF00D, 32'hCAFEF00D);

    // ALU result passes through with no wait.
    ifc.ex_to_mem_bus = mk(3'd0, 32'h1020, 1'b0, 1'b0, 1'b1, 5'd12, 32'h12345678);
    sb_q.push_back({32'h1020, 1'b1, 5'd12, 32'h12345678});
    tick();
    ifc.ex_to_mem_bus = '0;
    #1 chk("alu_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    tick();

    // Stray rvalid with no load in MEM.
    ifc.data_sram_rvalid = 1'b1;
    ifc.data_sram_rdata  = 32'h55555555;
    #1 chk("stray_rf", 70'(ifc.mem_to_rf_bus), 70'(0));
    tick();
    ifc.data_sram_rvalid = 1'b0;

    // rvalid under a two-cycle downstream stall: HELD, buffer reused, no re-stall.
    ifc.ex_to_mem_bus = mk(3'd0, 32'h2000, 1'b1, 1'b1, 1'b1, 5'd13, 32'h200);
    sb_q.push_back({32'h2000, 1'b1, 5'd13, 32'h13579BDF});
    tick();
    ifc.ex_to_mem_bus = '0;
    #1 chk("held_wait_stallreq", 70'(ifc.stallreq_for_mem), 70'(1));
    tick();
    ifc.data_sram_rvalid = 1'b1;
    ifc.data_sram_rdata  = 32'h13579BDF;
    tb_stall = 6'b011000;
    #1 chk("held_c1_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    chk("held_c1_rf", 70'(ifc.mem_to_rf_bus), 70'({1'b1, 5'd13, 32'h13579BDF}));
    tick();
    ifc.data_sram_rvalid = 1'b0;
    ifc.data_sram_rdata  = 32'hFFFF0000;
    #1 chk("held_c2_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    chk("held_c2_rf", 70'(ifc.mem_to_rf_bus), 70'({1'b1, 5'd13, 32'h13579BDF}));
    tick();
    tb_stall = '0;
    #1 chk("held_c3_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    tick();
    ifc.data_sram_rdata = '0;

    // Reset in the middle of a WAIT abandons the load.
    ifc.ex_to_mem_bus = mk(3'd0, 32'h3000, 1'b1, 1'b1, 1'b1, 5'd14, 32'h300);
    tick();
    ifc.ex_to_mem_bus = '0;
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("rstw_wb", 70'(ifc.mem_to_wb_bus), 70'(0));
    chk("rstw_rf", 70'(ifc.mem_to_rf_bus), 70'(0));
    chk("rstw_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    tick();
    resetn = 1'b1;
    ifc.data_sram_rvalid = 1'b1;
    ifc.data_sram_rdata  = 32'hAAAA5555;
    #1 chk("rstw_late_rf", 70'(ifc.mem_to_rf_bus), 70'(0));
    chk("rstw_late_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    tick();
    ifc.data_sram_rvalid = 1'b0;
    ifc.data_sram_rdata  = '0;

    // Bubble: MEM stopped while WB runs clears the input register.
    ifc.ex_to_mem_bus = mk(3'd0, 32'h4000, 1'b0, 1'b0, 1'b1, 5'd15, 32'h0BADCAFE);
    tick();
    ifc.ex_to_mem_bus = 79'(32'h77777777);
    tb_stall = 6'b001000;
    #1 chk("bub_before_we", 70'(ifc.mem_to_wb_bus[37]), 70'(1));
    tick();
    tb_stall = '0;
    ifc.ex_to_mem_bus = '0;
    #1 chk("bub_wb", 70'(ifc.mem_to_wb_bus), 70'(0));
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    ifc.ex_to_mem_bus = mk(3'd0, 32'h5000, 1'b1, 1'b1, 1'b1, 5'd16, 32'h102);
    tick();
    ifc.ex_to_mem_bus = '0;
    #1 chk("align_err", 70'(ifc.addr_err), 70'(1));
    chk("align_rfwe", 70'(ifc.mem_to_rf_bus[37]), 70'(0));
    chk("align_stallreq", 70'(ifc.stallreq_for_mem), 70'(0));
    tick();
    #1 chk("align_clear", 70'(ifc.addr_err), 70'(0));
    tick();
`else
    ifc.ex_to_mem_bus = mk(3'd0, 32'h5000, 1'b1, 1'b1, 1'b1, 5'd16, 32'h102);
    sb_q.push_back({32'h5000, 1'b1, 5'd16, 32'h11223344});
    tick();
    ifc.ex_to_mem_bus = '0;
    #1 chk("noalign_err", 70'(ifc.addr_err), 70'(0));
    chk("noalign_stallreq", 70'(ifc.stallreq_for_mem), 70'(1));
    tick();
    ifc.data_sram_rvalid = 1'b1;
    ifc.data_sram_rdata  = 32'h11223344;
    #1 chk("noalign_rf", 70'(ifc.mem_to_rf_bus), 70'({1'b1, 5'd16, 32'h11223344}));
    tick();
    ifc.data_sram_rvalid = 1'b0;
    ifc.data_sram_rdata  = '0;
`endif

    tick();
    tick();
    chk("sb_drained", 70'(sb_q.size()), 70'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Port clk  input  1  rising-edge clock for all state.
REQ-002 Port resetn  input  1  reset: one clock, asynchronous, active-low.
REQ-003 Port stall  input  StallBus  pipeline stall vector; bit 3 holds this stage, bit 4 holds the next stage; Stop=1.
REQ-004 Port ex_to_mem_bus  input  EX_TO_MEM_WD (79)  {mem_op[78:76], pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
REQ-005 Port data_sram_rdata  input  32  read data from data memory.
REQ-006 Port data_sram_rvalid  input  1  read data valid; one-cycle pulse, one or more cycles after the load entered MEM.
REQ-007 Port mem_to_wb_bus  output  MEM_TO_WB_WD (70)  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-008 Port mem_to_rf_bus  output  38  {rf_we, rf_waddr, rf_wdata}; forwarding path to ID.
REQ-009 Port stallreq_for_mem  output  1  stall request while load data is outstanding.
REQ-010 Port addr_err  output  1  misaligned access flag; present only under MEM_ALIGN_CHECK_EN.
REQ-011 mem_op encoding: 0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU, 5-7 reserved (treated as LW).

Function
REQ-012 Input register update priority: (1) stall[3]=Stop and stall[4]=NoStop loads all-zero (bubble); (2) stall[3]=NoStop loads ex_to_mem_bus; (3) otherwise holds.
REQ-013 A load is a registered op with ram_en=1 and ram_wen=0; all other ops complete in zero extra cycles.
REQ-014 FSM states: IDLE, WAIT, HELD.
REQ-015 IDLE: load present and rvalid=0 -> WAIT; load present and rvalid=1 -> data used this cycle, go HELD if stall[3]=Stop, else stay IDLE.
REQ-016 WAIT: rvalid=1 -> capture rdata into data_buf, go HELD if stall[3]=Stop, else IDLE; rvalid=0 -> stay WAIT.
REQ-017 HELD: data_buf drives the load result; leave to IDLE on the first cycle the input register advances (stall[3]=NoStop or bubble).
REQ-018 stallreq_for_mem=1 exactly when a load is present and the state is not HELD and rvalid=0; it is combinational, with no registered delay.
REQ-019 Raw load word = rvalid ? data_sram_rdata : data_buf.
REQ-020 Byte lane = ex_result[1:0]; half lane = ex_result[1]; LB/LH sign-extend, LBU/LHU zero-extend, to 32 bits.
REQ-021 rf_wdata = sel_rf_res ? extracted load data : ex_result.
REQ-022 rf_we is forced to 0 while stallreq_for_mem=1, so forwarding never sees stale data.
REQ-023 An rvalid arriving in IDLE with no load present is ignored.

Reset
REQ-024 resetn=0 asynchronously clears the input register, data_buf and addr_err, and sets the FSM to IDLE.
REQ-025 While resetn=0: mem_to_wb_bus=0, mem_to_rf_bus=0, stallreq_for_mem=0.
REQ-026 A reset asserted during WAIT abandons the load; a later rvalid for it is ignored.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN.
REQ-028 Defined: addr_err=1 for LW with ex_result[1:0]!=0, or LH/LHU with ex_result[0]=1.
REQ-029 Defined: when addr_err=1, rf_we is forced to 0 and the FSM stays IDLE (no wait, no stall).
REQ-030 Undefined: addr_err is tied 0 and unused low address bits are ignored.

Structure
REQ-031 Shared defines file holds EX_TO_MEM_WD, MEM_TO_WB_WD, the mem_op codes, the FSM state codes and Stop/NoStop.
REQ-032 The block has one natural sub-module, load_ext: combinational lane select plus extension.

Verification
REQ-033 Reset: resetn=0 for 1 cycle mid-WAIT -> outputs 0, state IDLE; a later rvalid produces no write.
REQ-034 LW at 0x100, rvalid 3 cycles later with 0xDEADBEEF -> stallreq_for_mem high for exactly 3 cycles; then rf_wdata=0xDEADBEEF, rf_we=1.
REQ-035 LB at 0x103 with rdata 0x80FF_1234 -> rf_wdata=0xFFFFFF80; LBU at the same address -> rf_wdata=0x00000080.
REQ-036 LH at 0x102 with rdata 0x8001_0000 -> rf_wdata=0xFFFF8001; LHU at the same address -> rf_wdata=0x00008001.
REQ-037 rvalid arrives while stall[3]=stall[4]=1 for 2 cycles -> state HELD, data_buf is reused, rf_wdata is stable, with no re-stall.
REQ-038 stall[3]=1 and stall[4]=0 -> bubble, mem_to_wb_bus=0 next cycle; under MEM_ALIGN_CHECK_EN, LW at 0x102 -> addr_err=1, rf_we=0.
